// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one 8-bit ALU between two requesters.
// Optional rsp_zero result flag is enabled by defining ALU_ARB_ZERO_FLAG_EN.
module alu_arbiter #(
    parameter int DATA_W = 8,
    parameter int SEL_W  = 3,
    parameter int NREQ   = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [NREQ*DATA_W-1:0] req_a,
    input  logic [NREQ*DATA_W-1:0] req_b,
    input  logic [NREQ*SEL_W-1:0]  req_sel,
    output logic [NREQ-1:0]        rsp_valid,
    input  logic [NREQ-1:0]        rsp_ready,
    output logic [DATA_W-1:0]      rsp_data,
    output logic                   rsp_carry,
    output logic [DATA_W-1:0]      alu_a,
    output logic [DATA_W-1:0]      alu_b,
    output logic [SEL_W-1:0]       alu_sel,
    input  logic [DATA_W-1:0]      alu_out,
    input  logic                   alu_carry,
`ifdef ALU_ARB_ZERO_FLAG_EN
    output logic                   rsp_zero,
`endif
    output logic                   busy
);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    state_t state_q;
    state_t state_d;

    logic grant_q;
    logic last_grant_q;
    logic winner;
    logic accept;
    logic rsp_done;

    always_comb begin
        state_d   = state_q;
        req_ready = '0;
        winner    = 1'b0;
        accept    = 1'b0;
        rsp_done  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (|req_valid) begin
                    // Tie goes to whoever was not served last
                    if (req_valid[0] && req_valid[1])
                        winner = ~last_grant_q;
                    else
                        winner = ~req_valid[0];
                    accept            = 1'b1;
                    req_ready[winner] = 1'b1;
                    state_d           = EXEC;
                end
            end
            EXEC: state_d = RESP;
            RESP: begin
                if (rsp_ready[grant_q]) begin
                    rsp_done = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy = (state_q != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            alu_a        <= '0;
            alu_b        <= '0;
            alu_sel      <= '0;
            rsp_data     <= '0;
            rsp_carry    <= 1'b0;
            rsp_valid    <= '0;
`ifdef ALU_ARB_ZERO_FLAG_EN
            rsp_zero     <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            if (accept) begin
                grant_q <= winner;
                if (winner) begin
                    alu_a   <= req_a[2*DATA_W-1:DATA_W];
                    alu_b   <= req_b[2*DATA_W-1:DATA_W];
                    alu_sel <= req_sel[2*SEL_W-1:SEL_W];
                end else begin
                    alu_a   <= req_a[DATA_W-1:0];
                    alu_b   <= req_b[DATA_W-1:0];
                    alu_sel <= req_sel[SEL_W-1:0];
                end
            end
            if (state_q == EXEC) begin
                rsp_data <= alu_out;
                // ALU leaves a stale carry on logic ops; only ADD/SUB own it
                rsp_carry <= (alu_sel[SEL_W-1:1] == '0) ? alu_carry : 1'b0;
`ifdef ALU_ARB_ZERO_FLAG_EN
                rsp_zero <= (alu_out == '0);
`endif
                rsp_valid          <= '0;
                rsp_valid[grant_q] <= 1'b1;
            end
            if (rsp_done) begin
                last_grant_q <= grant_q;
                rsp_valid    <= '0;
            end
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural ALU that
// drives a deliberately stale carry on non-arithmetic ops.
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [15:0] req_a;
    logic [15:0] req_b;
    logic [5:0]  req_sel;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready;
    logic [7:0]  rsp_data;
    logic        rsp_carry;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic [2:0]  alu_sel;
    logic [7:0]  alu_out;
    logic        alu_carry;
    logic        busy;
`ifdef ALU_ARB_ZERO_FLAG_EN
    logic        rsp_zero;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_sel   (req_sel),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_carry (rsp_carry),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_sel   (alu_sel),
        .alu_out   (alu_out),
        .alu_carry (alu_carry),
`ifdef ALU_ARB_ZERO_FLAG_EN
        .rsp_zero  (rsp_zero),
`endif
        .busy      (busy)
    );

    // External ALU: ADD, SUB(borrow), AND, OR, XOR, else 0
    logic [8:0] alu_t;
    always_comb begin
        alu_t = 9'h000;
        alu_carry = 1'b1;
        case (alu_sel)
            3'd0: begin
                alu_t = {1'b0, alu_a} + {1'b0, alu_b};
                alu_carry = alu_t[8];
            end
            3'd1: begin
                alu_t = {1'b0, alu_a} - {1'b0, alu_b};
                alu_carry = alu_t[8];
            end
            3'd2: alu_t = {1'b0, alu_a & alu_b};
            3'd3: alu_t = {1'b0, alu_a | alu_b};
            3'd4: alu_t = {1'b0, alu_a ^ alu_b};
            default: alu_t = 9'h000;
        endcase
        alu_out = alu_t[7:0];
    end

    typedef struct {
        logic [1:0] v;
        logic [7:0] a0;
        logic [7:0] b0;
        logic [2:0] s0;
        logic [7:0] a1;
        logic [7:0] b1;
        logic [2:0] s1;
        logic       g;
        logic [7:0] d;
        logic       c;
        logic       z;
    } vec_t;

    vec_t tbl[10];

    function automatic logic [1:0] oh(input logic g);
        return g ? 2'b10 : 2'b01;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Entered and left at a negedge with no request pending
    task automatic run_op(input vec_t t, input int idx);
        string n;
        n = $sformatf("op%0d", idx);
        req_valid = t.v;
        req_a     = {t.a1, t.a0};
        req_b     = {t.b1, t.b0};
        req_sel   = {t.s1, t.s0};
        rsp_ready = 2'b00;
        #1;
        chk({n, " req_ready"}, 32'(req_ready), 32'(oh(t.g)));
        chk({n, " idle busy"}, 32'(busy), 32'd0);
        @(negedge clk);
        req_valid[t.g] = 1'b0;
        #1;
        chk({n, " exec req_ready"}, 32'(req_ready), 32'd0);
        chk({n, " exec busy"}, 32'(busy), 32'd1);
        chk({n, " exec rsp_valid"}, 32'(rsp_valid), 32'd0);
        @(negedge clk);
        chk({n, " rsp_valid"}, 32'(rsp_valid), 32'(oh(t.g)));
        chk({n, " rsp_data"}, 32'(rsp_data), 32'(t.d));
        chk({n, " rsp_carry"}, 32'(rsp_carry), 32'(t.c));
`ifdef ALU_ARB_ZERO_FLAG_EN
        chk({n, " rsp_zero"}, 32'(rsp_zero), 32'(t.z));
`endif
        rsp_ready = oh(t.g);
        @(negedge clk);
        req_valid = 2'b00;
        rsp_ready = 2'b00;
        #1;
        chk({n, " done rsp_valid"}, 32'(rsp_valid), 32'd0);
        chk({n, " done busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t t;
        tbl[0] = '{2'b11, 8'hCC, 8'hAA, 3'd2, 8'hCC, 8'hAA, 3'd3, 1'b0, 8'h88, 1'b0, 1'b0};
        tbl[1] = '{2'b11, 8'hCC, 8'hAA, 3'd2, 8'hCC, 8'hAA, 3'd3, 1'b1, 8'hEE, 1'b0, 1'b0};
        tbl[2] = '{2'b01, 8'hF0, 8'h20, 3'd0, 8'h00, 8'h00, 3'd0, 1'b0, 8'h10, 1'b1, 1'b0};
        tbl[3] = '{2'b01, 8'h05, 8'h07, 3'd1, 8'h00, 8'h00, 3'd0, 1'b0, 8'hFE, 1'b1, 1'b0};
        tbl[4] = '{2'b10, 8'h00, 8'h00, 3'd0, 8'hFF, 8'h0F, 3'd4, 1'b1, 8'hF0, 1'b0, 1'b0};
        tbl[5] = '{2'b10, 8'h00, 8'h00, 3'd0, 8'h12, 8'h34, 3'd5, 1'b1, 8'h00, 1'b0, 1'b1};
        tbl[6] = '{2'b11, 8'hF0, 8'h0F, 3'd2, 8'h11, 8'h22, 3'd0, 1'b0, 8'h00, 1'b0, 1'b1};
        tbl[7] = '{2'b11, 8'hAB, 8'hCD, 3'd7, 8'hFF, 8'h01, 3'd0, 1'b1, 8'h00, 1'b1, 1'b1};
        tbl[8] = '{2'b10, 8'h00, 8'h00, 3'd0, 8'h07, 8'h05, 3'd1, 1'b1, 8'h02, 1'b0, 1'b0};
        tbl[9] = '{2'b01, 8'hAB, 8'hCD, 3'd6, 8'h00, 8'h00, 3'd0, 1'b0, 8'h00, 1'b0, 1'b1};

        rst       = 1'b1;
        req_valid = 2'b00;
        req_a     = 16'h0;
        req_b     = 16'h0;
        req_sel   = 6'h0;
        rsp_ready = 2'b00;
        repeat (2) @(negedge clk);
        chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset alu_a", 32'(alu_a), 32'd0);
        chk("reset alu_sel", 32'(alu_sel), 32'd0);
        chk("reset rsp_data", 32'(rsp_data), 32'd0);
        chk("reset busy", 32'(busy), 32'd0);
        rst = 1'b0;
        #1;
        chk("idle no valid ready", 32'(req_ready), 32'd0);
        @(negedge clk);

        for (int i = 0; i < 10; i++)
            run_op(tbl[i], i);

        // Response stall with the other requester waiting
        req_valid = 2'b01;
        req_a     = 16'h0001;
        req_b     = 16'h0002;
        req_sel   = 6'o00;
        @(negedge clk);
        req_valid = 2'b10;
        req_a     = 16'h5500;
        req_b     = 16'h0F00;
        req_sel   = 6'o30;
        @(negedge clk);
        rsp_ready = 2'b10;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("stall rsp_valid", 32'(rsp_valid), 32'd1);
            chk("stall rsp_data", 32'(rsp_data), 32'h03);
            chk("stall rsp_carry", 32'(rsp_carry), 32'd0);
            chk("stall req_ready", 32'(req_ready), 32'd0);
            chk("stall busy", 32'(busy), 32'd1);
            @(negedge clk);
        end
        rsp_ready = 2'b01;
        @(negedge clk);
        rsp_ready = 2'b00;
        chk("stall release rsp_valid", 32'(rsp_valid), 32'd0);
        chk("stall next ready", 32'(req_ready), 32'd2);
        req_valid = 2'b00;
        @(negedge clk);
        chk("dropped valid busy", 32'(busy), 32'd0);

        // Reset while in EXEC drops the op and restores priority
        req_valid = 2'b10;
        req_a     = 16'h3300;
        req_b     = 16'h0100;
        req_sel   = 6'o00;
        @(negedge clk);
        req_valid = 2'b00;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst rsp_valid", 32'(rsp_valid), 32'd0);
        chk("midrst alu_a", 32'(alu_a), 32'd0);
        chk("midrst alu_b", 32'(alu_b), 32'd0);
        chk("midrst rsp_data", 32'(rsp_data), 32'd0);
        chk("midrst busy", 32'(busy), 32'd0);
        repeat (3) begin
            @(negedge clk);
            chk("midrst no rsp", 32'(rsp_valid), 32'd0);
        end
        t = '{2'b11, 8'h0C, 8'h0A, 3'd3, 8'h40, 8'h40, 3'd0, 1'b0, 8'h0E, 1'b0, 1'b0};
        run_op(t, 10);

        // rsp_ready held high before the response appears
        rsp_ready = 2'b11;
        req_valid = 2'b10;
        req_a     = 16'h1000;
        req_b     = 16'h0100;
        req_sel   = 6'o10;
        #1;
        chk("hold ready grant", 32'(req_ready), 32'd2);
        @(negedge clk);
        req_valid = 2'b00;
        @(negedge clk);
        chk("hold rsp_valid", 32'(rsp_valid), 32'd2);
        chk("hold rsp_data", 32'(rsp_data), 32'h0F);
        chk("hold rsp_carry", 32'(rsp_carry), 32'd0);
        @(negedge clk);
        chk("hold one cycle", 32'(rsp_valid), 32'd0);
        chk("hold busy", 32'(busy), 32'd0);
        rsp_ready = 2'b00;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
